// File: rtl/ws2812_chain_driver.sv
// WS2812B chain driver: per-LED on/off bits select one of two colours,
// serialised MSB-first with bit timing and latch gap derived from CLK_FREQ.
module ws2812_chain_driver #(
  parameter int          CLK_FREQ  = 27_000_000,
  parameter int          NUM_LEDS  = 8,
  parameter logic [23:0] ON_COLOR  = 24'h00ff00,
  parameter logic [23:0] OFF_COLOR = 24'h000000,
  parameter int          RES_US    = 80
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ready,
  input  logic [NUM_LEDS-1:0] data,
  output logic                busy,
  output logic                data_latched,
  output logic                led_out
);

  localparam int BIT_CYC = CLK_FREQ / 800_000;
  localparam int T0H_CYC = CLK_FREQ * 2 / 5_000_000;
  localparam int T1H_CYC = CLK_FREQ * 4 / 5_000_000;
  localparam int RES_CYC = (CLK_FREQ / 1_000_000) * RES_US;
  localparam int MAX_CYC = (BIT_CYC > RES_CYC) ? BIT_CYC : RES_CYC;
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int LW = (NUM_LEDS > 1) ? $clog2(NUM_LEDS) : 1;

  localparam logic [TW-1:0] T0H_END = TW'(T0H_CYC - 1);
  localparam logic [TW-1:0] T1H_END = TW'(T1H_CYC - 1);
  localparam logic [TW-1:0] BIT_END = TW'(BIT_CYC - 1);
  localparam logic [TW-1:0] RES_END = TW'(RES_CYC - 1);
  localparam logic [LW-1:0] LAST_LED = LW'(NUM_LEDS - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_HIGH  = 2'd1;
  localparam logic [1:0] S_LOW   = 2'd2;
  localparam logic [1:0] S_LATCH = 2'd3;

  if (T1H_CYC >= BIT_CYC || T0H_CYC < 1 || NUM_LEDS < 1) begin : g_bad_cfg
    $error("ws2812_chain_driver: invalid timing or NUM_LEDS");
  end

  logic [1:0]          state;
  logic [NUM_LEDS-1:0] data_q;
  logic [LW-1:0]       led_idx;
  logic [4:0]          bit_idx;
  logic [TW-1:0]       timer;

  logic                cur_led;
  logic [23:0]         word;
  logic [4:0]          bit_pos;
  logic                cur_bit;
  logic [TW-1:0]       hi_end;
  logic                last_bit;

  always_comb begin
    cur_led  = data_q[led_idx];
    word     = cur_led ? ON_COLOR : OFF_COLOR;
    bit_pos  = 5'd23 - bit_idx;
    cur_bit  = word[bit_pos];
    hi_end   = cur_bit ? T1H_END : T0H_END;
    last_bit = (bit_idx == 5'd23) && (led_idx == LAST_LED);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= S_IDLE;
      data_q       <= '0;
      led_idx      <= '0;
      bit_idx      <= '0;
      timer        <= '0;
      busy         <= 1'b0;
      data_latched <= 1'b0;
      led_out      <= 1'b0;
    end else begin
      data_latched <= 1'b0;
      unique case (state)
        S_IDLE: begin
          if (ready) begin
            data_q       <= data;
            led_idx      <= '0;
            bit_idx      <= '0;
            timer        <= '0;
            state        <= S_HIGH;
            led_out      <= 1'b1;
            busy         <= 1'b1;
            data_latched <= 1'b1;
          end
        end
        S_HIGH: begin
          // timer keeps running so LOW ends on the full bit period
          timer <= timer + 1'b1;
          if (timer == hi_end) begin
            state   <= S_LOW;
            led_out <= 1'b0;
          end
        end
        S_LOW: begin
          if (timer == BIT_END) begin
            timer <= '0;
            if (last_bit) begin
              bit_idx <= '0;
              led_idx <= '0;
              state   <= S_LATCH;
            end else begin
              if (bit_idx == 5'd23) begin
                bit_idx <= '0;
                led_idx <= led_idx + 1'b1;
              end else begin
                bit_idx <= bit_idx + 1'b1;
              end
              state   <= S_HIGH;
              led_out <= 1'b1;
            end
          end else begin
            timer <= timer + 1'b1;
          end
        end
        S_LATCH: begin
          if (timer == RES_END) begin
            timer <= '0;
            state <= S_IDLE;
            busy  <= 1'b0;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: stimulus queues expected frames,
// a negedge monitor decodes led_out and checks timing against them.
module tb_ws2812_chain_driver;

  localparam int BIT_CYC  = 33;
  localparam int T1H      = 21;
  localparam int T0H      = 10;
  localparam int BUSY_LEN = 3744;
  localparam int GAP_LEN  = 2160;
  localparam int PERIOD   = 3745;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       ready = 1'b0;
  logic [1:0] data = 2'b00;
  logic       busy;
  logic       data_latched;
  logic       led_out;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [47:0] bits;
    int          gap;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  ws2812_chain_driver #(
    .CLK_FREQ (27_000_000),
    .NUM_LEDS (2),
    .ON_COLOR (24'hff0000),
    .OFF_COLOR(24'h000001),
    .RES_US   (80)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .ready       (ready),
    .data        (data),
    .busy        (busy),
    .data_latched(data_latched),
    .led_out     (led_out)
  );

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    repeat (n) tick();
  endtask

  task automatic expect_frame(input logic [47:0] b, input int g);
    sb.push_back('{bits: b, gap: g});
  endtask

  task automatic pulse(input logic [1:0] d);
    data  = d;
    ready = 1'b1;
    tick();
    ready = 1'b0;
  endtask

  // monitor: 0 idle, 1 decoding bits, 2 latch gap
  int   mst = 0;
  int   mcyc = 0;
  int   last_lat = -1;
  int   fcyc, bitn, hi, bcnt, gcnt, exp_hi;
  logic first;
  exp_t cur;

  always @(negedge clk) begin
    mcyc++;
    if (!rst) begin
      mst      = 0;
      last_lat = -1;
    end else begin
      if (data_latched) begin
        chk("latch_while_active", mst, 0);
        chk("latch_expected", (sb.size() > 0) ? 1 : 0, 1);
        if (sb.size() > 0) begin
          cur = sb.pop_front();
          chk("latch_outs", {30'd0, busy, led_out}, 3);
          if (cur.gap != 0) chk("period", mcyc - last_lat, cur.gap);
          mst  = 1;
          fcyc = 0;
          bitn = 0;
          hi   = 0;
          bcnt = 0;
          gcnt = 0;
        end
        last_lat = mcyc;
      end
      if (mst == 1) begin
        if (busy) bcnt++;
        if (led_out) hi++;
        if (fcyc % BIT_CYC == 0) first = led_out;
        if (fcyc % BIT_CYC == BIT_CYC - 1) begin
          exp_hi = cur.bits[47 - bitn] ? T1H : T0H;
          chk($sformatf("bit%0d_shape", bitn),
              (first ? 1000 : 0) + (led_out ? 100 : 0) + hi,
              1000 + exp_hi);
          hi = 0;
          bitn++;
          if (bitn == 48) mst = 2;
        end
        fcyc++;
      end else if (mst == 2) begin
        if (busy) begin
          bcnt++;
          gcnt++;
          if (led_out) chk("gap_low", 1, 0);
        end else begin
          chk("busy_len", bcnt, BUSY_LEN);
          chk("gap_len", gcnt, GAP_LEN);
          mst = 0;
        end
      end
    end
  end

  initial begin
    ticks(3);
    chk("reset_state", {29'd0, busy, led_out, data_latched}, 0);
    rst = 1'b1;
    ticks(3);
    chk("idle_after_reset", {29'd0, busy, led_out, data_latched}, 0);

    // single frame, LED0 on
    expect_frame(48'hff0000_000001, 0);
    pulse(2'b01);
    ticks(3750);

    // ready held high: three back-to-back frames
    expect_frame(48'hff0000_ff0000, 0);
    expect_frame(48'hff0000_ff0000, PERIOD);
    expect_frame(48'hff0000_ff0000, PERIOD);
    data  = 2'b11;
    ready = 1'b1;
    tick();
    ticks(2 * PERIOD);
    ready = 1'b0;
    ticks(3750);

    // data change mid-frame only affects the next frame
    expect_frame(48'hff0000_000001, 0);
    expect_frame(48'h000001_ff0000, PERIOD);
    data  = 2'b01;
    ready = 1'b1;
    tick();
    ticks(99);
    data = 2'b10;
    ticks(PERIOD - 99);
    ready = 1'b0;
    ticks(3750);

    // all LEDs off
    expect_frame(48'h000001_000001, 0);
    pulse(2'b00);
    ticks(3750);

    // async reset during HIGH of bit 5
    expect_frame(48'hff0000_000001, 0);
    pulse(2'b01);
    ticks(5 * BIT_CYC);
    #3;
    rst = 1'b0;
    #1;
    chk("rst_async", {29'd0, busy, led_out, data_latched}, 0);
    ticks(4);
    rst = 1'b1;
    ticks(50);
    chk("idle_after_rst", {30'd0, busy, led_out}, 0);
    expect_frame(48'hff0000_000001, 0);
    pulse(2'b01);
    ticks(3750);

    // ready rises in the final LATCH cycle
    expect_frame(48'hff0000_ff0000, 0);
    expect_frame(48'hff0000_ff0000, PERIOD);
    pulse(2'b11);
    ticks(BUSY_LEN - 1);
    ready = 1'b1;
    tick();
    chk("no_accept_in_latch", {30'd0, data_latched, busy}, 0);
    tick();
    chk("accept_from_idle", {31'd0, data_latched}, 1);
    ready = 1'b0;
    ticks(3750);

    chk("sb_drain", sb.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
